// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock project counters.
//   state_t  : timer FSM encoding (2 bits)
//   VAL_W    : width of every minute/second value
//   SEC_MAX  : largest second value (59)
//   clamp_val: saturates a value at a given limit
package clock_pkg;

   localparam int VAL_W   = 7;
   localparam int SEC_MAX = 59;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] val,
                                                   input logic [VAL_W-1:0] lim);
      return (val > lim) ? lim : val;
   endfunction

endpackage

// File: rtl/dcnt_60.sv
// Down counter with wrap at LIMIT (mod LIMIT+1), enable, parallel load,
// zero flag and borrow-out.
//   clk, rst (async, active-low)
//   en     : decrement by one (wraps 0 -> LIMIT)
//   ld     : load ld_val (wins over en)
//   ld_val : parallel load value
//   value  : current count, registered
//   zero   : value == 0
//   borrow : en while at zero, i.e. this decrement wraps
module dcnt_60
   import clock_pkg::*;
#(
   parameter int LIMIT = SEC_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [VAL_W-1:0] ld_val,
   output logic [VAL_W-1:0] value,
   output logic             zero,
   output logic             borrow
);

   localparam logic [VAL_W-1:0] LIM = VAL_W'(LIMIT);

   assign zero   = (value == '0);
   assign borrow = en && zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (ld) begin
         value <= ld_val;
      end else if (en) begin
         value <= zero ? LIM : (value - VAL_W'(1));
      end
   end

endmodule

// File: rtl/countdown_60.sv
// Minutes:seconds countdown timer. Loads a clamped mm:ss preset, counts it
// down once per one-second tick and flags expiry.
//   MAX_MIN             : largest loadable minute value
//   clk, rst            : clock, async active-low reset
//   tick                : one-second enable
//   load/set_min/set_sec: load preset (clamped to MAX_MIN:59)
//   start, pause        : run control pulses (priority load > pause > start)
//   min_value/sec_value : current value, registered
//   running, done       : state RUN / state DONE
//   done_pulse          : one-cycle strobe on expiry
// Optional build macro TIMER_AUTO_RELOAD_EN: on expiry reload from the preset
// and keep running instead of entering DONE.
//
// state    | meaning
// ST_IDLE  | loaded or reset, waiting for start
// ST_RUN   | counting down on tick
// ST_PAUSE | value held, waiting for start
// ST_DONE  | expired at 00:00, only load/reset leave
module countdown_60
   import clock_pkg::*;
#(
   parameter int MAX_MIN = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [VAL_W-1:0] set_min,
   input  logic [VAL_W-1:0] set_sec,
   input  logic             start,
   input  logic             pause,
   output logic [VAL_W-1:0] min_value,
   output logic [VAL_W-1:0] sec_value,
   output logic             running,
   output logic             done,
   output logic             done_pulse
);

   localparam logic [VAL_W-1:0] MIN_LIM = VAL_W'(MAX_MIN);
   localparam logic [VAL_W-1:0] SEC_LIM = VAL_W'(SEC_MAX);

   state_t           state, state_nxt;
   logic [VAL_W-1:0] min_clamp, sec_clamp;
   logic [VAL_W-1:0] ld_min, ld_sec;
   logic             cnt_ld, cnt_en, pulse_nxt;
   logic             min_zero, sec_zero, sec_borrow, min_borrow;
   logic             expiring;

   assign min_clamp = clamp_val(set_min, MIN_LIM);
   assign sec_clamp = clamp_val(set_sec, SEC_LIM);

   // The next decrement lands on 00:00.
   assign expiring = min_zero && (sec_value == VAL_W'(1));

`ifdef TIMER_AUTO_RELOAD_EN
   logic [VAL_W-1:0] preset_min, preset_sec;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         preset_min <= '0;
         preset_sec <= '0;
      end else if (load) begin
         preset_min <= min_clamp;
         preset_sec <= sec_clamp;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      cnt_ld    = 1'b0;
      cnt_en    = 1'b0;
      pulse_nxt = 1'b0;
      ld_min    = min_clamp;
      ld_sec    = sec_clamp;
      if (load) begin
         cnt_ld    = 1'b1;
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !(min_zero && sec_zero)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (pause) begin
                  state_nxt = ST_PAUSE;
               end else if (tick) begin
                  if (expiring) begin
                     pulse_nxt = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                     if ((preset_min != '0) || (preset_sec != '0)) begin
                        cnt_ld = 1'b1;
                        ld_min = preset_min;
                        ld_sec = preset_sec;
                     end else begin
                        cnt_en    = 1'b1;
                        state_nxt = ST_DONE;
                     end
`else
                     cnt_en    = 1'b1;
                     state_nxt = ST_DONE;
`endif
                  end else begin
                     cnt_en = 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (start) state_nxt = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         done_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_pulse <= pulse_nxt;
      end
   end

   assign running = (state == ST_RUN);
   assign done    = (state == ST_DONE);

   // Minutes only step on a seconds borrow; the FSM never decrements 00:00,
   // so the minute counter never wraps and min_borrow stays unused logic.
   assign min_borrow = 1'b0;

   dcnt_60 #(.LIMIT(SEC_MAX)) u_sec (
      .clk    (clk),
      .rst    (rst),
      .en     (cnt_en),
      .ld     (cnt_ld),
      .ld_val (ld_sec),
      .value  (sec_value),
      .zero   (sec_zero),
      .borrow (sec_borrow)
   );

   dcnt_60 #(.LIMIT(MAX_MIN)) u_min (
      .clk    (clk),
      .rst    (rst),
      .en     (sec_borrow | min_borrow),
      .ld     (cnt_ld),
      .ld_val (ld_min),
      .value  (min_value),
      .zero   (min_zero),
      .borrow ()
   );

endmodule

// File: doc/countdown_60.md
# countdown_60

Minutes:seconds countdown timer for the digital clock project. It is the down-counting counterpart of the up-counting mod-60 time chain. A preset mm:ss value is loaded, decremented once per one-second tick, and the block flags expiry. It sits beside the clock/stopwatch counters, shares the same one-second tick source, and drives the display mux with binary minute and second values.

## Interface
- `MAX_MIN`, default 59: largest loadable minute value.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-second enable, one `clk` wide, synchronous to `clk`.
- `load` in 1: load preset from `set_min`/`set_sec` (level sampled each cycle).
- `set_min` in 7: preset minutes; values > `MAX_MIN` are clamped to `MAX_MIN`.
- `set_sec` in 7: preset seconds; values > 59 are clamped to 59.
- `start` in 1: begin or resume counting (pulse).
- `pause` in 1: suspend counting (pulse).
- `min_value` out 7: current minutes, registered.
- `sec_value` out 7: current seconds, registered.
- `running` out 1: high in RUN.
- `done` out 1: level, high in DONE.
- `done_pulse` out 1: one-cycle strobe on expiry.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: state IDLE, `min_value` = 0, `sec_value` = 0, preset registers = 0, `running` = 0, `done` = 0, `done_pulse` = 0.
- Command priority in the same cycle: `load` > `pause` > `start`. `tick` is applied only when no command is accepted that cycle.
- `load`, in any state:
  - clamped preset goes into the preset registers and into `min_value`/`sec_value`;
  - next state is IDLE.
- IDLE:
  - `start` with a nonzero value goes to RUN.
  - `start` at 00:00 is ignored; state stays IDLE.
- RUN, on `tick`:
  - `sec_value` > 0: decrement `sec_value`.
  - `sec_value` = 0 and `min_value` > 0: decrement `min_value` and set `sec_value` to 59 (borrow).
  - If the decremented value is 00:00: go to DONE and assert `done_pulse` for one cycle.
- RUN: `pause` goes to PAUSE; the value is held and `tick` is ignored.
- PAUSE: `start` returns to RUN. `pause` is ignored.
- DONE:
  - Value holds at 00:00 and `done` stays high.
  - `start` and `pause` are ignored.
  - Only `load` or reset leaves DONE.
- Widths: all arithmetic is 7-bit unsigned. Underflow is impossible because 00:00 is never decremented.
- Reset asserted mid-count returns everything to reset values immediately and asynchronously.

## Timing
- All outputs are registered.
- Value change appears on the clock edge after the one sampling `tick`/`load` (1-cycle latency).
- `done_pulse` and the `done` rise appear on the same edge that shows 00:00.
- `running` follows the state register with no extra delay.
- `start` coincident with `tick` in PAUSE: the cycle's action is the transition to RUN only. The first decrement happens on the next `tick`.
- `pause` coincident with `tick` in RUN: no decrement; go to PAUSE.
- Back-to-back ticks on consecutive cycles are legal. Each tick decrements once.

## Configuration
- Macro `TIMER_AUTO_RELOAD_EN`.
- Defined: on expiry the value reloads from the preset registers on the same edge, the state stays RUN, `done_pulse` strobes, and `done` never asserts. A preset of 00:00 still goes to DONE.
- Undefined: the DONE behaviour above. The preset registers may be optimised away, except as needed for `load`.

## Structure
- Shared package/header `clock_pkg` holds:
  - state encodings IDLE/RUN/PAUSE/DONE (2 bits);
  - constants `SEC_MAX` = 59 and `VAL_W` = 7.
- Sub-module `dcnt_60`: mod-60 down counter with enable, parallel load, zero flag and borrow-out. It is instantiated for seconds; minutes use the same module with the limit set to `MAX_MIN`.
- The top level holds the FSM, clamping, preset registers and output flags.

## Test plan
- Reset mid-RUN at 03:17: outputs go to 00:00 and IDLE without waiting for `clk`; `done` = 0.
- Load 01:00, start, one tick: value 00:59 on the next edge with no `done_pulse`. After 59 more ticks: 00:00, `done_pulse` 1 cycle, `done` = 1.
- Load 70:75: value clamps to 59:59. Start at 00:00 after loading 00:00: stays IDLE, `running` = 0.
- RUN at 00:10, `pause` with `tick` in the same cycle: value stays 00:10 over 5 ticks. Then `start`: the next tick gives 00:09.
- In DONE, `start` is ignored. `load` 00:05 gives IDLE at 00:05 with `done` = 0.
- With `TIMER_AUTO_RELOAD_EN`, load 00:02, start, 2 ticks: `done_pulse`, value 00:02, `running` stays 1, `done` stays 0.
